// File: rtl/alu_defs.sv
// ----------------------------------------------------------------------------
// alu_defs
//   Shared definitions for the nibble-serial arithmetic path.
//   - state_e   : controller state encoding (IDLE / RUN / DONE)
//   - NIBBLE_W  : width of the shared adder slice
//   - OP_ADD / OP_SUB : encoding of the 'sub' request bit
// ----------------------------------------------------------------------------
package alu_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_defs

// File: rtl/FourBitAdder.sv
// ----------------------------------------------------------------------------
// FourBitAdder
//   Purely combinational 4-bit adder with carry in/out; the single datapath
//   slice that the serial controller time-shares across all nibbles.
//
//   Ports:
//     in1       in   NIBBLE_W  first addend nibble
//     in2       in   NIBBLE_W  second addend nibble
//     carry_in  in   1         incoming carry
//     sum       out  NIBBLE_W  sum nibble
//     carry_out out  1         outgoing carry
// ----------------------------------------------------------------------------
module FourBitAdder
    import alu_defs::*;
(
    input  logic [NIBBLE_W-1:0] in1,
    input  logic [NIBBLE_W-1:0] in2,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry_out
);

    // Widen by one bit so the carry falls out of the top of the addition.
    assign {carry_out, sum} = (NIBBLE_W+1)'(in1)
                            + (NIBBLE_W+1)'(in2)
                            + (NIBBLE_W+1)'(carry_in);

endmodule : FourBitAdder

// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   Adds or subtracts two WIDTH-bit operands through one shared 4-bit adder,
//   one nibble per clock, LSB nibble first. Subtraction is a + ~b + 1: the
//   B operand is inverted at capture and the carry register is seeded with 1.
//   WIDTH must be a multiple of 4 and at least 8.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     start      in   1      request, accepted only while ready=1
//     sub        in   1      sampled with start: 1 = op_a - op_b
//     op_a       in   WIDTH  first operand, sampled with start
//     op_b       in   WIDTH  second operand, sampled with start
//     clear      in   1      synchronous abort back to IDLE (beats start)
//     ready      out  1      high only in IDLE
//     busy       out  1      high in RUN
//     done       out  1      one-cycle pulse, result valid
//     result     out  WIDTH  sum/difference, stable from done to next start
//     carry_out  out  1      final carry (sub: 1 = no borrow)
//     overflow   out  1      two's-complement overflow
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import alu_defs::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             clear,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int               NIBBLES  = WIDTH / NIBBLE_W;
    localparam int               CNT_W    = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // already inverted for subtraction
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_done;
    logic               r_busy;
    logic               r_ready;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W-1:0] w_sum;
    logic                w_carry;
    logic [CNT_W+1:0]    w_lsb;

    // Bit offset of the active nibble: counter * 4, formed by concatenation
    // so the index is exactly as wide as a bit address into WIDTH.
    assign w_lsb   = {r_cnt, 2'b00};
    assign w_nib_a = r_a[w_lsb +: NIBBLE_W];
    assign w_nib_b = r_b[w_lsb +: NIBBLE_W];

    FourBitAdder u_adder (
        .in1       (w_nib_a),
        .in2       (w_nib_b),
        .carry_in  (r_carry),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches the flops.
    // NOTE: operand registers are reset along with the rest; they are only a
    // few flops, and it keeps the nibble mux free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else if (clear) begin
            // Abort: result flags keep their (now invalid) values.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= (sub == OP_SUB) ? ~op_b : op_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    r_result[w_lsb +: NIBBLE_W] <= w_sum;
                    r_carry                     <= w_carry;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_carry;
                        // Overflow: operands agree in sign, sum disagrees.
                        r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                                    && (w_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // start here is dropped, not queued.
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         clear;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .clear     (clear),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Counts every cycle in which done is observed high.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole words.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (s == 1'b0) begin
            r  = a + b;
            c  = (ua + ub) > 65535;
            sr = sa + sb;
        end else begin
            r  = a - b;
            c  = (ua >= ub);
            sr = sa - sb;
        end
        v = (sr > 32767) || (sr < -32768);
    endfunction

    // Presents a one-cycle start; returns 1 ns after the accepting edge E0.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; sub = s; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges counted until done is seen (-1 if the budget expires); rdy_low
    // reports whether ready stayed low for every sampled cycle up to done.
    task automatic wait_done(input int budget, output int lat, output logic rdy_low);
        lat     = -1;
        rdy_low = (ready === 1'b0);
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) rdy_low = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] r,
                                 input logic c, input logic v);
        int   lat;
        logic rl;
        issue(s, a, b);
        wait_done(20, lat, rl);
        check({tag, " latency"},   lat, 32'd4);
        check({tag, " ready_low"}, 32'(rl), 32'd1);
        check({tag, " result"},    32'(result), 32'(r));
        check({tag, " carry"},     32'(carry_out), 32'(c));
        check({tag, " overflow"},  32'(overflow), 32'(v));
        @(posedge clk); #1;
        check({tag, " done_1cyc"}, 32'(done), 32'd0);
        check({tag, " ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int           lat;
        int           d0;
        logic         rl;
        logic         rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] er;
        logic         ec;
        logic         ev;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; clear = 1'b0;
        op_a  = '0;   op_b  = '0;

        // Reset state
        #12;
        check("rst ready",    32'(ready),     32'd1);
        check("rst busy",     32'(busy),      32'd0);
        check("rst done",     32'(done),      32'd0);
        check("rst result",   32'(result),    32'd0);
        check("rst carry",    32'(carry_out), 32'd0);
        check("rst overflow", 32'(overflow),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                          vecs[i].r, vecs[i].c, vecs[i].v);

        // start during RUN cycle 2 is ignored
        d0 = done_cnt;
        issue(1'b0, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; op_a = 16'hAAAA; op_b = 16'h5555;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20, lat, rl);
        check("ign latency", lat, 32'd2);
        check("ign result",  32'(result), 32'h3333);
        @(posedge clk); #1;
        check("ign ready_back", 32'(ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("ign not_queued", 32'(busy), 32'd0);
        check("ign one_done",   done_cnt - d0, 32'd1);

        // clear during RUN cycle 2
        issue(1'b0, 16'h1234, 16'h1111);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr ready", 32'(ready), 32'd1);
        check("clr busy",  32'(busy),  32'd0);
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("clr no_done", done_cnt - d0, 32'd0);
        // clear beats start in IDLE
        start = 1'b1; clear = 1'b1; op_a = 16'h0003; op_b = 16'h0004;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        check("clr prio ready", 32'(ready), 32'd1);
        check("clr prio busy",  32'(busy),  32'd0);
        run_and_check("clr next", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        // asynchronous reset mid-RUN
        issue(1'b0, 16'h4321, 16'h1111);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst ready",    32'(ready),     32'd1);
        check("arst busy",     32'(busy),      32'd0);
        check("arst done",     32'(done),      32'd0);
        check("arst result",   32'(result),    32'd0);
        check("arst carry",    32'(carry_out), 32'd0);
        check("arst overflow", 32'(overflow),  32'd0);
        d0 = done_cnt;
        #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("arst no_done", done_cnt - d0, 32'd0);
        run_and_check("arst next", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = (i % 8 == 3) ? ra : 16'($urandom);
            model(rs, ra, rb, er, ec, ev);
            run_and_check($sformatf("rnd%0d", i), rs, ra, rb, er, ec, ev);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
